// File: rtl/mul_arbiter.sv
// Round-robin arbiter that shares one sequential multiplier among NREQ requesters.
// Each job clears the multiplier, pulses start for two cycles, waits, and returns the product.
module mul_arbiter #(
  parameter int NREQ = 3,
  parameter int N    = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*N-1:0]       op_a,
  input  logic [NREQ*N-1:0]       op_b,
  output logic [NREQ-1:0]         ack,
  output logic [2*N-1:0]          result,
  output logic [$clog2(NREQ)-1:0] grant_id,
  output logic                    busy,
  output logic                    mul_rst,
  output logic                    mul_start,
  output logic [N-1:0]            mul_a,
  output logic [N-1:0]            mul_b,
  input  logic [2*N-1:0]          mul_out,
  input  logic                    mul_busy
);

  localparam int IDW = $clog2(NREQ);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CLEAR  = 3'd1,
    START1 = 3'd2,
    START2 = 3'd3,
    WAIT   = 3'd4,
    DONE   = 3'd5
  } state_t;

  state_t           state_q, state_d;
  logic [IDW-1:0]   grant_id_q, grant_id_d;
  logic [IDW-1:0]   last_q, last_d;
  logic             mask_q, mask_d;
  logic [N-1:0]     mul_a_q, mul_a_d;
  logic [N-1:0]     mul_b_q, mul_b_d;
  logic [2*N-1:0]   result_q, result_d;
  logic [NREQ-1:0]  ack_q, ack_d;
  logic             busy_q, busy_d;
  logic             mul_start_q, mul_start_d;

  logic [NREQ-1:0]  req_eff;
  logic             found;
  int               win;

  // Round-robin search starting just after the last winner.
  always_comb begin
    req_eff = req;
    if (mask_q) req_eff[last_q] = 1'b0;
    found = 1'b0;
    win   = 0;
    for (int k = 1; k <= NREQ; k++) begin
      if (!found && req_eff[(int'(last_q) + k) % NREQ]) begin
        found = 1'b1;
        win   = (int'(last_q) + k) % NREQ;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    grant_id_d = grant_id_q;
    last_d     = last_q;
    mul_a_d    = mul_a_q;
    mul_b_d    = mul_b_q;
    result_d   = result_q;
    // The previous winner is ignored for one IDLE cycle so a dropping req is not re-granted.
    mask_d     = (state_q == DONE);
    case (state_q)
      IDLE: begin
        if (found) begin
          grant_id_d = IDW'(win);
          last_d     = IDW'(win);
          mul_a_d    = op_a[win*N +: N];
          mul_b_d    = op_b[win*N +: N];
          state_d    = CLEAR;
        end
      end
      CLEAR:  state_d = START1;
      START1: state_d = START2;
      START2: state_d = WAIT;
      WAIT: begin
        if (!mul_busy) begin
          result_d = mul_out;
          state_d  = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    ack_d = '0;
    if (state_d == DONE) ack_d[grant_id_q] = 1'b1;
    busy_d      = (state_d != IDLE);
    mul_start_d = (state_d == START1) || (state_d == START2);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      grant_id_q  <= '0;
      last_q      <= IDW'(NREQ - 1);
      mask_q      <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      result_q    <= '0;
      ack_q       <= '0;
      busy_q      <= 1'b0;
      mul_start_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      grant_id_q  <= grant_id_d;
      last_q      <= last_d;
      mask_q      <= mask_d;
      mul_a_q     <= mul_a_d;
      mul_b_q     <= mul_b_d;
      result_q    <= result_d;
      ack_q       <= ack_d;
      busy_q      <= busy_d;
      mul_start_q <= mul_start_d;
    end
  end

  assign ack       = ack_q;
  assign result    = result_q;
  assign grant_id  = grant_id_q;
  assign busy      = busy_q;
  assign mul_start = mul_start_q;
  assign mul_a     = mul_a_q;
  assign mul_b     = mul_b_q;
  assign mul_rst   = rst | (state_q == CLEAR);

endmodule

// File: tb/tb_mul_arbiter.sv
// Bench for mul_arbiter with a behavioural shift-add multiplier beside it.
// Expected acks are queued when requests are driven and checked when ack fires.
module tb_mul_arbiter;
  localparam int NREQ = 3;
  localparam int N    = 16;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NREQ-1:0]         req = '0;
  logic [NREQ*N-1:0]       op_a = '0;
  logic [NREQ*N-1:0]       op_b = '0;
  logic [NREQ-1:0]         ack;
  logic [2*N-1:0]          result;
  logic [$clog2(NREQ)-1:0] grant_id;
  logic                    busy, mul_rst, mul_start;
  logic [N-1:0]            mul_a, mul_b;
  logic [2*N-1:0]          mul_out;
  logic                    mul_busy;

  mul_arbiter #(.NREQ(NREQ), .N(N)) dut (
    .clk(clk), .rst(rst), .req(req), .op_a(op_a), .op_b(op_b),
    .ack(ack), .result(result), .grant_id(grant_id), .busy(busy),
    .mul_rst(mul_rst), .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b),
    .mul_out(mul_out), .mul_busy(mul_busy)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Multiplier model: rising-edge start, N shift-add steps, accumulator cleared only by reset.
  logic [2*N-1:0] m_acc, m_a;
  logic [N-1:0]   m_b;
  int             m_cnt;
  logic           m_st_q;
  always @(posedge clk) begin
    if (mul_rst) begin
      m_acc <= '0; m_a <= '0; m_b <= '0; m_cnt <= 0; m_st_q <= 1'b0;
    end else begin
      m_st_q <= mul_start;
      if (mul_start && !m_st_q) begin
        m_cnt <= N;
        m_a   <= {{N{1'b0}}, mul_a};
        m_b   <= mul_b;
      end else if (m_cnt != 0) begin
        if (m_b[0]) m_acc <= m_acc + m_a;
        m_a   <= m_a << 1;
        m_b   <= m_b >> 1;
        m_cnt <= m_cnt - 1;
      end
    end
  end
  assign mul_out  = m_acc;
  assign mul_busy = (m_cnt != 0);

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
  endtask

  typedef struct {
    logic [NREQ-1:0] ack;
    logic [2*N-1:0]  res;
    int              gid;
    int              cyc;
  } sb_t;
  sb_t sb[$];

  task automatic push_exp(input int id, input logic [2*N-1:0] res, input int at);
    sb_t e;
    e.ack = '0;
    e.ack[id] = 1'b1;
    e.res = res;
    e.gid = id;
    e.cyc = at;
    sb.push_back(e);
  endtask

  // Monitor: every ack pops one expected job; acks must last a single cycle.
  initial begin
    logic [NREQ-1:0] ack_prev;
    sb_t e;
    ack_prev = '0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (ack_prev != '0) chk("ack_single_cycle", 64'(ack), 64'(0));
        if (ack != '0) begin
          if (sb.size() == 0) chk("unexpected_ack", 64'(ack), 64'(0));
          else begin
            e = sb.pop_front();
            chk("ack", 64'(ack), 64'(e.ack));
            chk("result", 64'(result), 64'(e.res));
            chk("grant_id", 64'(grant_id), 64'(e.gid));
            chk("ack_cycle", 64'(cyc), 64'(e.cyc));
          end
        end
      end
      ack_prev = ack;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    req = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic set_ops(input int id, input logic [N-1:0] a, input logic [N-1:0] b);
    op_a[id*N +: N] = a;
    op_b[id*N +: N] = b;
  endtask

  // One isolated job; optionally drops req shortly after the grant.
  task automatic job(input int id, input logic [N-1:0] a, input logic [N-1:0] b,
                     input logic [2*N-1:0] exp, input bit drop);
    bit got;
    @(posedge clk); #1;
    set_ops(id, a, b);
    req[id] = 1'b1;
    push_exp(id, exp, cyc + N + 4);
    got = 1'b0;
    for (int t = 0; t < N + 20; t++) begin
      @(negedge clk);
      if (drop && t == 3) req[id] = 1'b0;
      if (ack[id]) begin got = 1'b1; break; end
    end
    if (!got) chk("job_timeout", 64'(0), 64'(1));
    @(posedge clk); #1;
    req[id] = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  typedef struct {
    int              id;
    logic [N-1:0]    a;
    logic [N-1:0]    b;
    logic [2*N-1:0]  exp;
    bit              drop;
  } vec_t;
  vec_t vecs[8];

  int rr_cnt[NREQ];
  int rr_ph[NREQ];

  initial begin
    int k;
    int seen;
    vecs[0] = '{0, 16'h0003, 16'h0005, 32'h0000000F, 1'b0};
    vecs[1] = '{2, 16'hFFFF, 16'hFFFF, 32'hFFFE0001, 1'b0};
    vecs[2] = '{2, 16'h0002, 16'h0003, 32'h00000006, 1'b0};
    vecs[3] = '{1, 16'h0000, 16'h1234, 32'h00000000, 1'b0};
    vecs[4] = '{1, 16'h1234, 16'hABCD, 32'd204951460, 1'b0};
    vecs[5] = '{0, 16'h8000, 16'h0002, 32'h00010000, 1'b1};
    vecs[6] = '{2, 16'h0001, 16'hFFFF, 32'h0000FFFF, 1'b0};
    vecs[7] = '{1, 16'hFFFF, 16'h0001, 32'h0000FFFF, 1'b1};

    // Reset values, sampled while reset is held.
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack", 64'(ack), 64'(0));
    chk("rst_result", 64'(result), 64'(0));
    chk("rst_grant_id", 64'(grant_id), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_mul_start", 64'(mul_start), 64'(0));
    chk("rst_mul_ab", 64'({mul_a, mul_b}), 64'(0));
    chk("rst_mul_rst", 64'(mul_rst), 64'(1));
    @(posedge clk); #1 rst = 1'b0;

    foreach (vecs[i]) job(vecs[i].id, vecs[i].a, vecs[i].b, vecs[i].exp, vecs[i].drop);

    // Withdrawal before grant: req[1] pulses while req[0] is in flight.
    do_reset();
    @(posedge clk); #1;
    set_ops(0, 16'd9, 16'd11);
    set_ops(1, 16'd5, 16'd5);
    req[0] = 1'b1;
    push_exp(0, 32'd99, cyc + N + 4);
    @(posedge clk); #1;
    chk("busy_in_clear", 64'(busy), 64'(1));
    req[1] = 1'b1;
    repeat (5) @(posedge clk);
    #1 req[1] = 1'b0;
    seen = 0;
    for (int t = 0; t < N + 20 && seen == 0; t++) begin
      @(negedge clk);
      if (ack[0]) seen = 1;
    end
    if (seen == 0) chk("withdraw_timeout", 64'(0), 64'(1));
    @(posedge clk); #1 req[0] = 1'b0;
    repeat (30) @(posedge clk);

    // Round-robin: all requesting, each drops for one cycle after its ack.
    do_reset();
    @(posedge clk); #1;
    for (int i = 0; i < NREQ; i++) begin
      set_ops(i, 16'(i + 10), 16'(i + 20));
      rr_cnt[i] = 0;
      rr_ph[i] = 0;
    end
    k = cyc;
    for (int j = 0; j < 6; j++)
      push_exp(j % NREQ, 32'((j % NREQ + 10) * (j % NREQ + 20)), k + N + 4 + j * (N + 5));
    req = '1;
    for (int t = 0; t < 6 * (N + 5) + 10; t++) begin
      @(posedge clk); #1;
      for (int i = 0; i < NREQ; i++) begin
        if (rr_ph[i] == 1) begin req[i] = 1'b0; rr_ph[i] = 2; end
        else if (rr_ph[i] == 2) begin req[i] = (rr_cnt[i] < 2); rr_ph[i] = 0; end
      end
      for (int i = 0; i < NREQ; i++)
        if (ack[i]) begin rr_cnt[i]++; rr_ph[i] = 1; end
    end
    chk("rr_ack_total", 64'(rr_cnt[0] + rr_cnt[1] + rr_cnt[2]), 64'(6));
    req = '0;
    repeat (5) @(posedge clk);

    // Masking: req[1] held continuously gives one ack every N+6 cycles.
    do_reset();
    @(posedge clk); #1;
    set_ops(1, 16'd100, 16'd200);
    k = cyc;
    for (int j = 0; j < 3; j++) push_exp(1, 32'd20000, k + N + 4 + j * (N + 6));
    req[1] = 1'b1;
    seen = 0;
    for (int t = 0; t < 3 * (N + 6) + 20 && seen < 3; t++) begin
      @(negedge clk);
      if (ack[1]) seen++;
    end
    chk("mask_ack_count", 64'(seen), 64'(3));
    @(posedge clk); #1 req[1] = 1'b0;
    repeat (30) @(posedge clk);

    // Reset mid-job at cycle 8: nothing acked, then a fresh job completes.
    @(posedge clk); #1;
    set_ops(0, 16'h00FF, 16'h00FF);
    req[0] = 1'b1;
    k = cyc;
    while (cyc < k + 8) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(negedge clk);
    chk("midrst_mul_rst", 64'(mul_rst), 64'(1));
    @(posedge clk); #1;
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    chk("midrst_busy", 64'(busy), 64'(0));
    chk("midrst_mul_start", 64'(mul_start), 64'(0));
    chk("midrst_ack", 64'(ack), 64'(0));
    chk("midrst_result", 64'(result), 64'(0));
    repeat (N + 10) @(posedge clk);
    job(0, 16'd7, 16'd9, 32'd63, 1'b0);

    repeat (5) @(posedge clk);
    chk("scoreboard_drained", 64'(sb.size()), 64'(0));
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/mul_arbiter.md
# mul_arbiter

Round-robin arbiter and sequencer that shares one `mul` sequential multiplier among `NREQ` requesters in the stepper-driver datapath, such as the step-rate and acceleration calculators. It grants one requester at a time and latches that requester's operands. It then clears and starts the multiplier, waits for completion, and returns the 2N-bit product with a one-cycle acknowledge. The `mul` instance sits beside this block. Its `rst` input is driven by `mul_rst`, because `mul` accumulates into `out` and only clears it on reset.

## Interface
- `NREQ`, default 3: number of requesters, 2..8.
- `N`, default 16: operand width; must match the `mul` instance.

- `clk`  in  1  clock.
- `rst`  in  1  reset: synchronous, active-high.
- `req`  in  NREQ  per-requester level request; held high until the matching `ack`.
- `op_a`  in  NREQ*N  packed operand A; requester i uses `[i*N +: N]`. Must be stable while `req[i]` is high.
- `op_b`  in  NREQ*N  packed operand B, same packing as `op_a`.
- `ack`  out  NREQ  one-hot, one-cycle pulse: `result` is valid for that requester.
- `result`  out  2N  unsigned product of the last completed job; held until the next `DONE`.
- `grant_id`  out  $clog2(NREQ)  index of the requester currently or last served.
- `busy`  out  1  high in every state except `IDLE`.
- `mul_rst`  out  1  to `mul.rst`; equals `rst` OR (state==`CLEAR`).
- `mul_start`  out  1  to `mul.start`.
- `mul_a`, `mul_b`  out  N  to `mul.in_a` / `mul.in_b`; the latched operands.
- `mul_out`  in  2N  from `mul.out`.
- `mul_busy`  in  1  from `mul.busy`.

## Operation
- Reset values: `ack`=0, `result`=0, `grant_id`=0, `busy`=0, `mul_start`=0, `mul_a`=`mul_b`=0, state `IDLE`.
- Reset sets the round-robin pointer `last`=NREQ-1, so requester 0 has first priority.
- FSM states:
  - `IDLE`: find the first requester with `req` high, searching `last+1, last+2, …` with wrap modulo NREQ. On a hit, register `grant_id`, latch `mul_a`/`mul_b` from that slice, set `last`=winner, and go to `CLEAR`.
  - `CLEAR`: one cycle with `mul_rst`=1, which zeroes `mul.out` and `mul.count`. Go to `START1`.
  - `START1`, `START2`: `mul_start`=1 for exactly two cycles, which covers the edge-detector latency. Go to `WAIT`.
  - `WAIT`: `mul_start`=0. When `mul_busy`=0, register `result`<=`mul_out` and go to `DONE`.
  - `DONE`: `ack[grant_id]`=1 for one cycle, then go to `IDLE`.
- `mul_start` is low in every state except `START1` and `START2`. This guarantees a fresh rising edge for every job.
- Masking: in the first `IDLE` cycle after `DONE`, `req[last]` is ignored, so a requester that drops `req` on seeing `ack` is not re-granted.
- Withdrawal:
  - `req` dropped before grant: the request is withdrawn and no `ack` is issued.
  - `req` dropped after grant: the job completes and `ack` still pulses.
- `req` changes during `CLEAR` through `DONE` have no effect on the job in flight.
- The product is exact and unsigned; there is no truncation or saturation.
- Reset mid-job (`rst` in any state): return to `IDLE` with the reset values above. `mul_rst` is asserted the same cycle. No `ack` is issued for the aborted job.

## Timing
- Throughput: one job per N+5 cycles. `IDLE` re-arbitrates on the cycle immediately after `DONE`.
- Grant-to-ack latency is N+4 cycles, counting cycle 0 as the `IDLE` cycle where the grant is taken. It breaks down as:
  - `CLEAR`: cycle 1.
  - `START1`, `START2`: cycles 2-3.
  - `mul.count` is loaded with N on the edge ending cycle 2 and reaches 0 on the edge ending cycle N+2.
  - `WAIT`: cycles 4..N+3; it sees `mul_busy`=0 at cycle N+3.
  - `DONE`: cycle N+4, with `ack` and `result` valid.
- `result` and `ack` are registered. `result` changes only on the edge entering `DONE`.

## Test plan
- Single job: `req[0]`=1, A=0x0003, B=0x0005 → at cycle N+4 after the grant (20 for N=16), `ack`=3'b001, `result`=0x0000000F.
- Full-scale: A=B=0xFFFF on requester 2 → `result`=0xFFFE0001 and `grant_id`=2. A following job with 2×3 returns exactly 6, proving the accumulator is cleared between jobs.
- Round-robin: all three `req` held high, each requester dropping `req` the cycle after its own `ack` and re-raising it → grant order 0,1,2,0,1,2. Each `ack` is a single cycle, and consecutive `ack` pulses are N+5 cycles apart.
- Fairness with masking: only `req[1]` is held continuously, never dropped → grants are separated by one extra idle cycle, and `ack[1]` repeats every N+6 cycles.
- Zero operand: A=0, B=0x1234 → `result`=0 with the full N+4 latency.
- Reset mid-job: assert `rst` at cycle 8 of a job → no `ack`, `busy`=0 and `mul_start`=0 the next cycle. A request issued afterwards completes correctly with a fresh product.
